// File: rtl/hps_sample_capture_ctrl_if.sv
// Avalon-MM slave bus bundle for the sample capture controller.
// The master drives address and strobes; the slave returns readdata.
interface hps_sample_capture_ctrl_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/hps_sample_capture_ctrl.sv
// Threshold-triggered ADC capture buffer drained over Avalon-MM.
// Define CAPTURE_IRQ_EN to build the capture-complete interrupt.
module hps_sample_capture_ctrl #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  hps_sample_capture_ctrl_if.slave avs,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     sample_valid,
  output logic                     irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] thresh_q, thresh_d;
  logic [CNT_W-1:0]  length_q, length_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              below_q, below_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head_q;
  logic              mem_we;
  logic              wr_ctrl, arm, abort, pop;

  assign avs.readdata = rdata_q;
  assign irq          = irq_q;

  // Next-state for the sequencer, register file, irq and read data.
  always_comb begin
    state_d  = state_q;
    thresh_d = thresh_q;
    length_d = length_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    below_d  = below_q;
    irq_en_d = irq_en_q;
    irq_d    = irq_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;

    wr_ctrl = avs.write && (avs.address == 3'd0);
    arm     = wr_ctrl && avs.writedata[0];
    abort   = wr_ctrl && avs.writedata[1];
    pop     = avs.read && (avs.address == 3'd4) &&
              (state_q == S_DONE) && !abort &&
              (count_q != '0);

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          below_d  = 1'b0;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        if (sample_valid) begin
          below_d = sample_in < thresh_q;
          if (below_q && sample_in >= thresh_q) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = CNT_W'(1);
            state_d  = (length_q == CNT_W'(1)) ?
                       S_DONE : S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (sample_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CNT_W'(1);
          if (count_q + CNT_W'(1) == length_q)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1))
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      below_d  = 1'b0;
    end

    if (avs.write && state_q == S_IDLE) begin
      if (avs.address == 3'd1)
        thresh_d = avs.writedata[DATA_W-1:0];
      if (avs.address == 3'd2) begin
        if (avs.writedata == 32'd0)
          length_d = CNT_W'(1);
        else if (avs.writedata > 32'(DEPTH))
          length_d = CNT_W'(DEPTH);
        else
          length_d = avs.writedata[CNT_W-1:0];
      end
    end

`ifdef CAPTURE_IRQ_EN
    if (wr_ctrl)
      irq_en_d = avs.writedata[2];
    if (state_q == S_DONE && state_d != S_DONE)
      irq_d = 1'b0;
    if (wr_ctrl && avs.writedata[3])
      irq_d = 1'b0;
    if (state_q != S_DONE && state_d == S_DONE && irq_en_d)
      irq_d = 1'b1;
    if (abort || !irq_en_d)
      irq_d = 1'b0;
`else
    irq_en_d = 1'b0;
    irq_d    = 1'b0;
`endif

    if (avs.read) begin
      rdata_d = '0;
      unique case (1'b1)
        avs.address == 3'd0: rdata_d[2] = irq_en_q;
        avs.address == 3'd1: rdata_d[DATA_W-1:0] = thresh_q;
        avs.address == 3'd2: rdata_d[CNT_W-1:0] = length_q;
        avs.address == 3'd3: begin
          rdata_d[1:0]       = state_q;
          rdata_d[CNT_W+7:8] = count_q;
          rdata_d[31]        = irq_q;
        end
        avs.address == 3'd4: begin
          if (pop) begin
            rdata_d[31]         = 1'b1;
            rdata_d[DATA_W-1:0] = head_q;
          end
        end
        default: rdata_d = '0;
      endcase
    end
  end

  // Control and status flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      thresh_q <= '0;
      length_q <= CNT_W'(DEPTH);
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      below_q  <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      thresh_q <= thresh_d;
      length_q <= length_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      below_q  <= below_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  // Sample RAM; head word prefetched at the next read pointer,
  // bypassing a same-edge write so a just-stored sample is seen.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr_q] <= sample_in;
    if (mem_we && wr_ptr_q == rd_ptr_d)
      head_q <= sample_in;
    else
      head_q <= mem[rd_ptr_d];
  end

endmodule

// File: tb/tb_hps_sample_capture_ctrl.sv
// Self-checking bench for hps_sample_capture_ctrl.
// Register vectors, capture sequences and a randomized queue model.
module tb_hps_sample_capture_ctrl;

  localparam int DEPTH = 256;
`ifdef CAPTURE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] sample_in;
  logic       sample_valid;
  logic       irq;

  hps_sample_capture_ctrl_if bus ();

  hps_sample_capture_ctrl #(
    .DATA_W(9), .DEPTH(DEPTH), .CNT_W(13)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs(bus.slave),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  logic [31:0] rq[$];

  typedef struct {
    bit          is_wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic drain(input int n);
    rq.delete();
    @(negedge clk);
    bus.address = 3'd4; bus.read = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rq.push_back(bus.readdata);
      if (i == n - 1) bus.read = 1'b0;
    end
  endtask

  task automatic send(input logic [8:0] s);
    @(negedge clk);
    sample_in = s; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic rchk(input string nm, input logic [2:0] a,
                      input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(nm, v, exp);
  endtask

  logic [31:0] v;
  int          th, len, ie, st, below;
  logic [8:0]  mq[$];
  logic [8:0]  s;
  bit          vld;

  initial begin
    reset = 1'b1;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0;
    sample_in = '0; sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_irq", {31'd0, irq}, 32'd0);

    vt.push_back('{0, 3'd0, 0, 32'd0, "rst_ctrl"});
    vt.push_back('{0, 3'd1, 0, 32'd0, "rst_thresh"});
    vt.push_back('{0, 3'd2, 0, 32'(DEPTH), "rst_length"});
    vt.push_back('{0, 3'd3, 0, 32'd0, "rst_status"});
    vt.push_back('{0, 3'd4, 0, 32'd0, "rst_data"});
    vt.push_back('{0, 3'd6, 0, 32'd0, "rst_addr6"});
    vt.push_back('{1, 3'd1, 32'hFFFF_FFFF, 0, "thr_w"});
    vt.push_back('{0, 3'd1, 0, 32'h1FF, "thr_mask"});
    vt.push_back('{1, 3'd2, 32'd0, 0, "len_w0"});
    vt.push_back('{0, 3'd2, 0, 32'd1, "len_zero"});
    vt.push_back('{1, 3'd2, 32'd5000, 0, "len_w5000"});
    vt.push_back('{0, 3'd2, 0, 32'(DEPTH), "len_clamp"});
    vt.push_back('{1, 3'd2, 32'd256, 0, "len_w256"});
    vt.push_back('{0, 3'd2, 0, 32'd256, "len_depth"});
    vt.push_back('{1, 3'd5, 32'd77, 0, "a5_w"});
    vt.push_back('{0, 3'd5, 0, 32'd0, "a5_rd"});
    vt.push_back('{1, 3'd0, 32'd4, 0, "ie_w"});
    vt.push_back('{0, 3'd0, 0, {29'd0, IRQ_ON, 2'd0}, "ie_rd"});
    vt.push_back('{1, 3'd0, 32'd0, 0, "ie_clr"});
    vt.push_back('{0, 3'd0, 0, 32'd0, "ie_rd0"});

    foreach (vt[i]) begin
      if (vt[i].is_wr) wr(vt[i].a, vt[i].d);
      else rchk(vt[i].nm, vt[i].a, vt[i].exp);
    end

    // Main capture: trigger on 110 after 90 dips below 100.
    wr(3'd1, 32'd100);
    wr(3'd2, 32'd4);
    wr(3'd0, 32'd1);
    rchk("armed", 3'd3, 32'd1);
    send(9'd120); send(9'd90); send(9'd110); send(9'd111);
    send(9'd112); send(9'd113); send(9'd114);
    rchk("done_status", 3'd3, 32'h0000_0403);
    chk("done_noirq", {31'd0, irq}, 32'd0);
    drain(5);
    chk("pop0", rq[0], 32'h8000_006E);
    chk("pop1", rq[1], 32'h8000_006F);
    chk("pop2", rq[2], 32'h8000_0070);
    chk("pop3", rq[3], 32'h8000_0071);
    chk("pop_empty", rq[4], 32'd0);
    rchk("back_idle", 3'd3, 32'd0);

    // No dip below threshold: stays armed.
    wr(3'd0, 32'd1);
    send(9'd150); send(9'd150); send(9'd150);
    rchk("no_trig", 3'd3, 32'd1);
    wr(3'd2, 32'd7);
    rchk("len_armed", 3'd2, 32'd4);
    wr(3'd0, 32'd2);
    rchk("abort_arm", 3'd3, 32'd0);

    // Interrupt on single-sample capture.
    wr(3'd2, 32'd1);
    wr(3'd0, 32'd5);
    send(9'd0);
    @(negedge clk);
    sample_in = 9'd200; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
    rchk("irq_status", 3'd3, {IRQ_ON, 23'd0, 8'h03} | 32'h100);
    wr(3'd0, 32'd12);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rchk("clr_status", 3'd3, 32'h0000_0103);
    drain(2);
    chk("irq_pop", rq[0], 32'h8000_00C8);
    chk("irq_pop_empty", rq[1], 32'd0);
    wr(3'd0, 32'd0);

    // Abort mid-capture.
    wr(3'd2, 32'd8);
    wr(3'd0, 32'd1);
    send(9'd10); send(9'd200); send(9'd201); send(9'd202);
    rchk("cap3", 3'd3, 32'h0000_0302);
    wr(3'd0, 32'd2);
    rchk("abort_cap", 3'd3, 32'd0);
    rchk("abort_data", 3'd4, 32'd0);
    wr(3'd0, 32'd3);
    rchk("arm_abort", 3'd3, 32'd0);

    // Randomized captures against a queue model.
    for (int it = 0; it < 12; it++) begin
      th  = int'($urandom_range(0, 511));
      len = (it % 4 == 3) ? int'($urandom_range(13, 40))
                          : int'($urandom_range(1, 12));
      ie  = int'($urandom_range(0, 1));
      wr(3'd1, 32'(th));
      wr(3'd2, 32'(len));
      wr(3'd0, 32'(1 | (ie << 2)));
      st = 1; below = 0; mq.delete();
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        vld = 1'($urandom_range(0, 1));
        s   = 9'($urandom_range(0, 511));
        sample_in = s; sample_valid = vld;
        if (vld) begin
          if (st == 1) begin
            if (below != 0 && int'(s) >= th) begin
              mq.push_back(s);
              st = (len == 1) ? 3 : 2;
            end
            below = (int'(s) < th) ? 1 : 0;
          end else if (st == 2) begin
            mq.push_back(s);
            if (mq.size() == len) st = 3;
          end
        end
      end
      @(negedge clk);
      sample_valid = 1'b0;
      chk("rnd_irq", {31'd0, irq},
          {31'd0, IRQ_ON && st == 3 && ie == 1});
      rchk("rnd_status", 3'd3,
           {(IRQ_ON && st == 3 && ie == 1), 10'd0,
            13'(mq.size()), 6'd0, 2'(st)});
      if (st == 3) begin
        drain(mq.size() + 1);
        foreach (mq[k])
          chk("rnd_pop", rq[k], {1'b1, 22'd0, mq[k]});
        chk("rnd_pop_empty", rq[mq.size()], 32'd0);
      end else begin
        wr(3'd0, 32'd2);
      end
      rchk("rnd_idle", 3'd3, 32'd0);
      wr(3'd0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
